// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_mux8 transmit path and its slot counter.
package tdm_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 3-bit slot counter: synchronous clear (priority over enable), wraps 7->0 when enabled,
// exposes its next value so the top can register outputs for the coming slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [SEL_W-1:0] slot,
    output logic [SEL_W-1:0] slot_nxt,
    output logic             last
);

    always_comb begin
        slot_nxt = slot;
        if (clr) begin
            slot_nxt = '0;
        end else if (en) begin
            slot_nxt = slot + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else begin
            slot <= slot_nxt;
        end
    end

    assign last = (slot == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_mux8.sv
// Time-division 8:1 mux: captures a lane word and emits lane k in slot k with registered outputs.
// Optional TDM_MUX8_PARITY_EN adds a registered even-parity output `par` held for the frame.
module tdm_mux8
    import tdm_pkg::*;
#(
    parameter int GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             y,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic             frame,
    output logic             busy,
`ifdef TDM_MUX8_PARITY_EN
    output logic             par,
`endif
    output logic [1:0]       state_dbg
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic             NO_GAP   = (GAP == 0);

    tdm_state_e       state_q, state_nxt;
    logic [LANES-1:0] shadow_q, shadow_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic [SEL_W-1:0] slot, slot_nxt;
    logic             last, accept, slot_en, slot_clr;

    logic             shift_nxt, y_nxt, frame_nxt, busy_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             y_q, frame_q, busy_q;
    logic [SEL_W-1:0] sel_q;

    // Handshake: a word is taken on any rising edge where load && ready; a load seen
    // while ready is low is dropped, not held. ready is combinational and low during rst.
    assign ready  = !rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_SHIFT) && last && NO_GAP));
    assign accept = load && ready;

    // Counter runs only while shifting; it wraps 7->0 only when a back-to-back word arrives.
    assign slot_en  = (state_q == ST_SHIFT);
    assign slot_clr = (state_q != ST_SHIFT) || (last && !accept);

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (slot_en),
        .clr      (slot_clr),
        .slot     (slot),
        .slot_nxt (slot_nxt),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            gap_q    <= '0;
            y_q      <= 1'b0;
            sel_q    <= '0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            shadow_q <= shadow_nxt;
            gap_q    <= gap_nxt;
            y_q      <= y_nxt;
            sel_q    <= sel_nxt;
            frame_q  <= frame_nxt;
            busy_q   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        shadow_nxt = shadow_q;
        gap_nxt    = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt  = ST_SHIFT;
                    shadow_nxt = d;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    if (accept) begin
                        shadow_nxt = d;
                    end else if (NO_GAP) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_LAST;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state/slot so the registers show the slot being entered.
    always_comb begin
        shift_nxt = (state_nxt == ST_SHIFT);
        y_nxt     = shift_nxt && shadow_nxt[slot_nxt];
        sel_nxt   = shift_nxt ? slot_nxt : '0;
        frame_nxt = shift_nxt && (slot_nxt == '0);
        busy_nxt  = shift_nxt;
    end

`ifdef TDM_MUX8_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= shift_nxt && (^shadow_nxt);
        end
    end

    assign par = par_q;
`endif

    assign y            = y_q;
    assign {s2, s1, s0} = sel_q;
    assign frame        = frame_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8: three instances (GAP 0/3/2) against a frame-timeline reference model,
// a vector table, and hand-written multi-cycle sequences. Honours TDM_MUX8_PARITY_EN.
module tb_tdm_mux8;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d    [N];
    logic       load [N];
    logic       ready[N], y[N], s2[N], s1[N], s0[N], frame[N], busy[N], par[N];
    logic [1:0] state_dbg[N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdm_mux8 #(.GAP(0)) u0 (
        .clk(clk), .rst(rst), .d(d[0]), .load(load[0]), .ready(ready[0]), .y(y[0]),
        .s2(s2[0]), .s1(s1[0]), .s0(s0[0]), .frame(frame[0]), .busy(busy[0]),
`ifdef TDM_MUX8_PARITY_EN
        .par(par[0]),
`endif
        .state_dbg(state_dbg[0])
    );

    tdm_mux8 #(.GAP(3)) u1 (
        .clk(clk), .rst(rst), .d(d[1]), .load(load[1]), .ready(ready[1]), .y(y[1]),
        .s2(s2[1]), .s1(s1[1]), .s0(s0[1]), .frame(frame[1]), .busy(busy[1]),
`ifdef TDM_MUX8_PARITY_EN
        .par(par[1]),
`endif
        .state_dbg(state_dbg[1])
    );

    tdm_mux8 #(.GAP(2)) u2 (
        .clk(clk), .rst(rst), .d(d[2]), .load(load[2]), .ready(ready[2]), .y(y[2]),
        .s2(s2[2]), .s1(s1[2]), .s0(s0[2]), .frame(frame[2]), .busy(busy[2]),
`ifdef TDM_MUX8_PARITY_EN
        .par(par[2]),
`endif
        .state_dbg(state_dbg[2])
    );

    // Reference model: t = cycles since capture (-1 = never / reset), w = captured word.
    int         t [N];
    logic [7:0] w [N];

    function automatic int gap_of(int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic m_idle(int i);
        return (t[i] < 0) || (t[i] >= 8 + gap_of(i));
    endfunction

    function automatic logic m_ready(int i);
        return !rst && (m_idle(i) || (t[i] == 7 && gap_of(i) == 0));
    endfunction

    // Packed as {y, sel[2:0], frame, busy, ready, par}.
    function automatic logic [7:0] m_exp(int i);
        logic       in_slot;
        logic [2:0] k;
        logic       p;
        in_slot = (t[i] >= 0) && (t[i] < 8);
        k       = 3'(t[i]);
        p       = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
        p = in_slot && (^w[i]);
`endif
        return {in_slot && w[i][k], in_slot ? k : 3'd0, in_slot && (t[i] == 0),
                in_slot, m_ready(i), p};
    endfunction

    function automatic logic [7:0] act_of(int i);
        logic p;
        p = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
        p = par[i];
`endif
        return {y[i], s2[i], s1[i], s0[i], frame[i], busy[i], ready[i], p};
    endfunction

    function automatic void model_update();
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                t[i] = -1;
                w[i] = '0;
            end else if (load[i] && m_ready(i)) begin
                t[i] = 0;
                w[i] = d[i];
            end else if (!m_idle(i)) begin
                t[i]++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Vector table for instance 0 (GAP=0); exp = {y, sel[2:0], frame, busy, ready}.
    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] d;
        logic [6:0] exp;
    } vec_t;

    vec_t       vecs [16];
    logic       vec_active = 1'b0;
    logic [6:0] vec_exp;
    int         vec_idx;
    logic [7:0] obs [N];

    function automatic vec_t mk(logic r, logic l, logic [7:0] dv, logic ey, logic [2:0] es,
                                logic ef, logic eb, logic er);
        vec_t v;
        v.rst  = r;
        v.load = l;
        v.d    = dv;
        v.exp  = {ey, es, ef, eb, er};
        return v;
    endfunction

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            obs[i] = act_of(i);
            chk($sformatf("model_u%0d", i), 32'(obs[i]), 32'(m_exp(i)));
        end
        if (vec_active) chk($sformatf("vec_%0d", vec_idx), 32'(obs[0][7:1]), 32'(vec_exp));
        model_update();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ybits;
    logic [12:0] bbits, rbits;
    logic [7:0]  pbits;
    int          busy_cnt;
    logic [5:0]  sel_pair;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            load[i] = 1'b0;
            d[i]    = '0;
            t[i]    = -1;
            w[i]    = '0;
        end
        cycle();
        cycle();

        // Table: reset with load ignored, A5 frame, idle, then reset in slot 3 of a 0F frame.
        vecs[0]  = mk(1, 1, 8'hFF, 0, 3'd0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'hA5, 0, 3'd0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 8'h00, 1, 3'd0, 1, 1, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0, 3'd1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 8'h00, 1, 3'd2, 0, 1, 0);
        vecs[5]  = mk(0, 0, 8'h00, 0, 3'd3, 0, 1, 0);
        vecs[6]  = mk(0, 0, 8'h00, 0, 3'd4, 0, 1, 0);
        vecs[7]  = mk(0, 0, 8'h00, 1, 3'd5, 0, 1, 0);
        vecs[8]  = mk(0, 0, 8'h00, 0, 3'd6, 0, 1, 0);
        vecs[9]  = mk(0, 0, 8'h00, 1, 3'd7, 0, 1, 1);
        vecs[10] = mk(0, 1, 8'h0F, 0, 3'd0, 0, 0, 1);
        vecs[11] = mk(0, 0, 8'h00, 1, 3'd0, 1, 1, 0);
        vecs[12] = mk(0, 0, 8'h00, 1, 3'd1, 0, 1, 0);
        vecs[13] = mk(0, 0, 8'h00, 1, 3'd2, 0, 1, 0);
        vecs[14] = mk(1, 0, 8'h00, 1, 3'd3, 0, 1, 0);
        vecs[15] = mk(0, 0, 8'h00, 0, 3'd0, 0, 0, 1);
        for (int v = 0; v < 16; v++) begin
            rst        = vecs[v].rst;
            load[0]    = vecs[v].load;
            d[0]       = vecs[v].d;
            vec_active = 1'b1;
            vec_exp    = vecs[v].exp;
            vec_idx    = v;
            cycle();
        end
        vec_active = 1'b0;
        rst        = 1'b0;
        load[0]    = 1'b0;

        // Back-to-back on GAP=0: FF then 00 with load held, no bubble at the 7->0 boundary.
        load[0] = 1'b1;
        d[0]    = 8'hFF;
        cycle();
        d[0]     = 8'h00;
        busy_cnt = 0;
        ybits    = '0;
        sel_pair = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == 15) load[0] = 1'b0;
            cycle();
            ybits[c] = obs[0][7];
            busy_cnt += int'(obs[0][2]);
            if (c == 7) sel_pair[5:3] = obs[0][6:4];
            if (c == 8) sel_pair[2:0] = obs[0][6:4];
        end
        chk("b2b_y", 32'(ybits), 32'h00FF);
        chk("b2b_busy", busy_cnt, 16);
        chk("b2b_sel_wrap", 32'(sel_pair), {26'd0, 3'd7, 3'd0});
        cycle();
        chk("b2b_idle_after", 32'(obs[0][2]), 0);

        // GAP=3 with load held: 8 busy, 3 gap with ready low, 1 idle, next frame.
        load[1] = 1'b1;
        d[1]    = 8'h81;
        cycle();
        bbits = '0;
        rbits = '0;
        for (int c = 0; c < 13; c++) begin
            cycle();
            bbits[c] = obs[1][2];
            rbits[c] = obs[1][1];
        end
        chk("gap3_busy", 32'(bbits), 32'h10FF);
        chk("gap3_ready", 32'(rbits), 32'h0800);
        load[1] = 1'b0;
        for (int c = 0; c < 12; c++) cycle();

        // GAP=2: load in slot 4 ignored, d changed mid-frame; slots still carry 5A.
        load[2] = 1'b1;
        d[2]    = 8'h5A;
        cycle();
        load[2] = 1'b0;
        pbits   = '0;
        rbits   = '0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                load[2] = 1'b1;
                d[2]    = 8'h3C;
            end
            if (c == 5) begin
                load[2] = 1'b0;
                d[2]    = 8'hFF;
            end
            cycle();
            pbits[c] = obs[2][7];
            rbits[c] = obs[2][1];
        end
        chk("midload_y", 32'(pbits), 32'h5A);
        chk("midload_ready", 32'(rbits[7:0]), 0);
        for (int c = 0; c < 4; c++) cycle();

`ifdef TDM_MUX8_PARITY_EN
        // Parity held through all eight slots: 07 is odd-weight, 03 is even-weight.
        load[0] = 1'b1;
        d[0]    = 8'h07;
        cycle();
        load[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            pbits[c] = obs[0][0];
        end
        chk("par_07", 32'(pbits), 32'hFF);
        cycle();
        load[0] = 1'b1;
        d[0]    = 8'h03;
        cycle();
        load[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            pbits[c] = obs[0][0];
        end
        chk("par_03", 32'(pbits), 32'h00);
        cycle();
`endif

        // Randomised traffic on all instances with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                load[i] = ($urandom_range(0, 3) != 0);
                d[i]    = 8'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) load[i] = 1'b0;
        for (int c = 0; c < 14; c++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_mux8.md
# tdm_mux8

Time-division 8:1 multiplexer: captures an 8-bit lane word and serialises it one lane per clock onto a single line, driving the 3-bit slot select (`s2`,`s1`,`s0`) alongside. It is the transmit end of the 1:8 demultiplexer path: `y` feeds the demux data input and `s2..s0` feed its select inputs, so demux output `yk` receives lane `k` in slot `k`. Registered outputs, one clock domain, back-to-back frames supported.

## Interface
- `GAP`, default 0: idle cycles inserted between frames (0..15).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  8  lane word; `d[k]` is lane k.
- `load`  in  1  capture request; accepted when `load && ready`.
- `ready`  out  1  block can accept a word this cycle.
- `y`  out  1  serial data; lane k during slot k.
- `s2`, `s1`, `s0`  out  1 each  current slot index, `{s2,s1,s0}` = k.
- `frame`  out  1  high during slot 0 only.
- `busy`  out  1  high during any slot 0..7.
- `par`  out  1  only with `TDM_MUX8_PARITY_EN`; see Configuration.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `ready`=1; `y`=0, `{s2,s1,s0}`=000, `frame`=0, `busy`=0. Accept → latch `d` into shadow register, go SHIFT, slot 0.
- SHIFT: slot counter 0..7 increments each cycle; `y` = shadow[slot]; `busy`=1; `frame`=1 only in slot 0.
- At slot 7: if `GAP`=0 and `load` is accepted that cycle, the next cycle is slot 0 of the new frame (no bubble). If `GAP`=0 and no load, go IDLE. If `GAP`>0, go GAP.
- GAP: outputs as IDLE but `ready`=0; down-counter of `GAP` cycles, then IDLE.
- `ready` = IDLE, or (SHIFT && slot==7 && `GAP`==0); forced 0 while `rst`=1.
- `load` while not ready is ignored; `d` changes after capture do not affect the frame in flight.
- Slot counter is 3 bits, wraps 7→0 only on a back-to-back capture.

## Timing
- Capture at edge n (load && ready sampled high) → slot 0 on outputs after edge n, i.e. `y`, select, `frame` registered, latency 1 clock.
- Slot k visible in cycle n+1+k; frame length 8 cycles; frame period 8+`GAP` cycles, plus 1 IDLE cycle when `GAP`>0 (no back-to-back after a gap).
- Reset values (cycle after `rst` sampled high): state IDLE, `y`=0, `{s2,s1,s0}`=000, `frame`=0, `busy`=0, `par`=0, shadow=0.
- Reset mid-frame: frame abandoned at next edge, no further slots emitted; `load` in the same cycle as `rst` ignored.

## Configuration
- `TDM_MUX8_PARITY_EN` defined: port `par` exists; registered even parity (XOR) of the captured word, held through slots 0..7, 0 in IDLE/GAP.
- Not defined: no `par` port, no parity logic; all other behaviour identical.

## Structure
- Shared package `tdm_pkg`: state enum (IDLE, SHIFT, GAP), `LANES`=8, `SEL_W`=3.
- One sub-module `tdm_slot_ctr`: 3-bit slot counter with enable, synchronous clear, and `last` flag (slot==7); the FSM and shadow register stay in the top.

## Test plan
- Reset, then `d`=8'b1010_0101, one `load` pulse → `y` = 1,0,1,0,0,1,0,1 in slots 0..7, select 000..111, `frame` high in slot 0 only, then IDLE outputs.
- `GAP`=0, `load` held high with `d`=8'hFF then 8'h00 → 16 contiguous busy cycles, `y` eight 1s then eight 0s, select 7→0 without bubble.
- `GAP`=3, `load` held high → 8 busy cycles, 3 GAP cycles with `ready`=0, 1 IDLE, next frame.
- `load` with `d`=8'h3C during slot 4 of a frame (`GAP`=2) → ignored; `d` changed mid-frame → slots unaffected.
- `rst` asserted in slot 3 → next cycle `y`=0, select 000, `busy`=0, `ready`=1 after release.
- With `TDM_MUX8_PARITY_EN`, `d`=8'h07 → `par`=1 through all 8 slots; `d`=8'h03 → `par`=0.
